// File: rtl/transformation_ctrl.sv
// GCN transformation step: FM_WM[r][c] = dot(feature_row[r], weight_col[c]).
// Walks the weight columns in the outer loop and the feature rows, via the external counter, in the inner loop.
module transformation_ctrl #(
  parameter int FEATURE_ROWS          = 6,
  parameter int FEATURE_COLS          = 96,
  parameter int WEIGHT_COLS           = 3,
  parameter int DATA_WIDTH            = 5,
  parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS),
  parameter int COUNTER_WEIGHT_WIDTH  = $clog2(WEIGHT_COLS),
  parameter int DOT_WIDTH             = 2*DATA_WIDTH + $clog2(FEATURE_COLS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [COUNTER_FEATURE_WIDTH-1:0]   feature_count,
  output logic                               incr_feature,
  output logic                               read_weight_en,
  output logic [COUNTER_WEIGHT_WIDTH-1:0]    read_weight_addr,
  input  logic [FEATURE_COLS*DATA_WIDTH-1:0] weight_col_in,
  output logic                               read_feature_en,
  output logic [COUNTER_FEATURE_WIDTH-1:0]   read_feature_addr,
  input  logic [FEATURE_COLS*DATA_WIDTH-1:0] feature_row_in,
  output logic                               fm_wm_wr_en,
  output logic [COUNTER_FEATURE_WIDTH-1:0]   fm_wm_row,
  output logic [COUNTER_WEIGHT_WIDTH-1:0]    fm_wm_col,
  output logic [DOT_WIDTH-1:0]               fm_wm_data,
  output logic                               done
);

  typedef enum logic [2:0] {IDLE, W_REQ, W_CAP, F_REQ, F_CAP, MAC, WRITE, DONE} state_t;

  localparam logic [COUNTER_FEATURE_WIDTH-1:0] LAST_ROW = COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1);
  localparam logic [COUNTER_WEIGHT_WIDTH-1:0]  LAST_COL = COUNTER_WEIGHT_WIDTH'(WEIGHT_COLS - 1);

  state_t                              state, state_nxt;
  logic [COUNTER_WEIGHT_WIDTH-1:0]     wcol_cnt, wcol_cnt_nxt;
  logic [FEATURE_COLS*DATA_WIDTH-1:0]  weight_buf, feature_buf;
  logic [DOT_WIDTH-1:0]                result, dot;
  logic [2*DATA_WIDTH-1:0]             prod;

  assign read_feature_addr = feature_count;

  // Full-precision sum; DOT_WIDTH is sized so the worst case cannot overflow.
  always_comb begin
    dot  = '0;
    prod = '0;
    for (int i = 0; i < FEATURE_COLS; i++) begin
      prod = (2*DATA_WIDTH)'(feature_buf[i*DATA_WIDTH +: DATA_WIDTH]) *
             (2*DATA_WIDTH)'(weight_buf[i*DATA_WIDTH +: DATA_WIDTH]);
      dot  = dot + DOT_WIDTH'(prod);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wcol_cnt    <= '0;
      weight_buf  <= '0;
      feature_buf <= '0;
      result      <= '0;
    end else begin
      state    <= state_nxt;
      wcol_cnt <= wcol_cnt_nxt;
      if (state == W_CAP) weight_buf  <= weight_col_in;
      if (state == F_CAP) feature_buf <= feature_row_in;
      if (state == MAC)   result      <= dot;
    end
  end

  always_comb begin
    state_nxt        = state;
    wcol_cnt_nxt     = wcol_cnt;
    incr_feature     = 1'b0;
    read_weight_en   = 1'b0;
    read_weight_addr = '0;
    read_feature_en  = 1'b0;
    fm_wm_wr_en      = 1'b0;
    fm_wm_row        = '0;
    fm_wm_col        = '0;
    fm_wm_data       = '0;
    done             = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = W_REQ;
      W_REQ: begin
        read_weight_en   = 1'b1;
        read_weight_addr = wcol_cnt;
        state_nxt        = W_CAP;
      end
      W_CAP: state_nxt = F_REQ;
      F_REQ: begin
        read_feature_en = 1'b1;
        state_nxt       = F_CAP;
      end
      F_CAP: state_nxt = MAC;
      MAC:   state_nxt = WRITE;
      WRITE: begin
        fm_wm_wr_en  = 1'b1;
        fm_wm_row    = feature_count;
        fm_wm_col    = wcol_cnt;
        fm_wm_data   = result;
        incr_feature = 1'b1;
        // The external counter wraps to 0 on this same edge after the last row.
        if (feature_count != LAST_ROW) begin
          state_nxt = F_REQ;
        end else if (wcol_cnt != LAST_COL) begin
          wcol_cnt_nxt = wcol_cnt + COUNTER_WEIGHT_WIDTH'(1);
          state_nxt    = W_REQ;
        end else begin
          wcol_cnt_nxt = '0;
          state_nxt    = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_transformation_ctrl.sv
// Directed bench for transformation_ctrl with behavioural weight/feature memories and feature-row counter.
module tb_transformation_ctrl;
  localparam int FR = 6, FC = 96, WC = 3, DW = 5, CFW = 3, CWW = 2, DOTW = 17;

  logic clk = 1'b0;
  logic reset, start;
  logic [CFW-1:0]   feature_count;
  logic             incr_feature, read_weight_en, read_feature_en, fm_wm_wr_en, done;
  logic [CWW-1:0]   read_weight_addr, fm_wm_col;
  logic [CFW-1:0]   read_feature_addr, fm_wm_row;
  logic [FC*DW-1:0] weight_col_in, feature_row_in;
  logic [DOTW-1:0]  fm_wm_data;

  logic [FC*DW-1:0] fmem [FR];
  logic [FC*DW-1:0] wmem [WC];

  transformation_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .feature_count(feature_count),
    .incr_feature(incr_feature), .read_weight_en(read_weight_en),
    .read_weight_addr(read_weight_addr), .weight_col_in(weight_col_in),
    .read_feature_en(read_feature_en), .read_feature_addr(read_feature_addr),
    .feature_row_in(feature_row_in), .fm_wm_wr_en(fm_wm_wr_en), .fm_wm_row(fm_wm_row),
    .fm_wm_col(fm_wm_col), .fm_wm_data(fm_wm_data), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (read_weight_en)  weight_col_in  <= wmem[read_weight_addr];
    if (read_feature_en) feature_row_in <= fmem[read_feature_addr];
  end

  always @(posedge clk or posedge reset) begin
    if (reset) feature_count <= '0;
    else if (incr_feature) feature_count <= (feature_count == CFW'(FR-1)) ? '0 : feature_count + 1'b1;
  end

  int checks = 0, failures = 0;
  int nwr, nincr, done_cyc, bad_zero, bad_addr;
  logic [31:0] last_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_dot(input int r, input int c);
    int s = 0;
    for (int i = 0; i < FC; i++) s += int'(fmem[r][i*DW +: DW]) * int'(wmem[c][i*DW +: DW]);
    return s;
  endfunction

  // mode 0: row r = r+1, col c = c+1; 1: all 31; 2: alternating 0/31 vs 31/0
  task automatic load(input int mode);
    for (int r = 0; r < FR; r++)
      for (int i = 0; i < FC; i++)
        fmem[r][i*DW +: DW] = (mode == 0) ? DW'(r+1) : (mode == 1) ? 5'd31 : ((i % 2) ? 5'd31 : 5'd0);
    for (int c = 0; c < WC; c++)
      for (int i = 0; i < FC; i++)
        wmem[c][i*DW +: DW] = (mode == 0) ? DW'(c+1) : (mode == 1) ? 5'd31 : ((i % 2) ? 5'd0 : 5'd31);
  endtask

  function automatic int outs_or();
    return int'(incr_feature) | int'(read_weight_en) | int'(read_weight_addr) | int'(read_feature_en)
         | int'(fm_wm_wr_en) | int'(fm_wm_row) | int'(fm_wm_col) | int'(fm_wm_data) | int'(done);
  endfunction

  // Cycle 0 is the edge sampling start; stop_k >= 0 returns at the negedge of write number stop_k.
  task automatic do_run(input bit hold, input int stop_k, input string tag);
    int cyc, er, ec;
    bit fin;
    nwr = 0; nincr = 0; done_cyc = -1; bad_zero = 0; bad_addr = 0; last_data = '0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 if (!hold) start = 1'b0;
    cyc = 1; fin = 0;
    while (!fin && cyc < 200) begin
      @(negedge clk);
      if (incr_feature) nincr++;
      if (incr_feature !== fm_wm_wr_en) bad_zero++;
      if (read_feature_en && read_feature_addr !== feature_count) bad_addr++;
      if (read_weight_en && int'(read_weight_addr) != nwr / FR) bad_addr++;
      if (fm_wm_wr_en) begin
        er = nwr % FR; ec = nwr / FR;
        chk({tag, "_row"},   32'(fm_wm_row),  32'(er));
        chk({tag, "_col"},   32'(fm_wm_col),  32'(ec));
        chk({tag, "_data"},  32'(fm_wm_data), 32'(model_dot(er, ec)));
        chk({tag, "_cycle"}, 32'(cyc),        32'(6 + 26*ec + 4*er));
        last_data = 32'(fm_wm_data);
        if (nwr == stop_k) fin = 1;
        nwr++;
      end else if ((int'(fm_wm_row) | int'(fm_wm_col) | int'(fm_wm_data)) != 0) bad_zero++;
      if (done) begin done_cyc = cyc; fin = 1; end
      cyc++;
    end
    if (stop_k < 0) begin
      chk({tag, "_done_cycle"}, 32'(done_cyc), 32'd79);
      chk({tag, "_writes"},     32'(nwr),      32'd18);
      chk({tag, "_incr"},       32'(nincr),    32'd18);
      chk({tag, "_cnt_wrap"},   32'(feature_count), 32'd0);
      chk({tag, "_zero_idle"},  32'(bad_zero), 32'd0);
      chk({tag, "_rd_addr"},    32'(bad_addr), 32'd0);
    end else begin
      chk({tag, "_reached"}, 32'(nwr), 32'(stop_k + 1));
    end
  endtask

  initial begin
    int bad;
    reset = 1'b1; start = 1'b0;
    load(0);
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'(outs_or()), 32'd0);
    chk("reset_state", 32'(dut.state), 32'd0);
    reset = 1'b0;

    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (outs_or() != 0) bad++;
    end
    chk("idle_outs", 32'(bad), 32'd0);
    chk("idle_state", 32'(dut.state), 32'd0);
    chk("idle_cnt", 32'(feature_count), 32'd0);

    load(0);
    do_run(1'b0, -1, "uniform");
    chk("uniform_last_1728", last_data, 32'd1728);

    load(1);
    do_run(1'b0, -1, "max");
    chk("max_92256", last_data, 32'd92256);

    load(0);
    do_run(1'b0, 9, "abort");
    reset = 1'b1;
    #1;
    chk("rst_outs", 32'(outs_or()), 32'd0);
    chk("rst_cnt", 32'(feature_count), 32'd0);
    chk("rst_state", 32'(dut.state), 32'd0);
    @(negedge clk); reset = 1'b0;
    do_run(1'b0, -1, "rerun");

    do_run(1'b1, -1, "hold1");
    do_run(1'b1, -1, "hold2");
    chk("hold2_last", last_data, 32'd1728);
    start = 1'b0;

    load(2);
    do_run(1'b0, -1, "alt");
    chk("alt_zero", last_data, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
